// File: rtl/roll_scheduler_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : roll_scheduler_if
// Brief    : Key-pulse inputs and generator/result strobes of roll_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
interface roll_scheduler_if #(
   parameter int STEP_W = 8
);
   logic              i_start;
   logic              i_pause;
   logic              o_tick;
   logic              o_capture;
   logic              o_busy;
   logic              o_paused;
   logic              o_done;
   logic [STEP_W-1:0] o_step;

   modport master (
      output i_start, i_pause,
      input  o_tick, o_capture, o_busy, o_paused, o_done, o_step
   );

   modport slave (
      input  i_start, i_pause,
      output o_tick, o_capture, o_busy, o_paused, o_done, o_step
   );
endinterface

`default_nettype wire

// File: rtl/roll_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : roll_scheduler
// Brief    : Decelerating roll sequencer: NUM_STEPS advance ticks with a
//            growing gap, capture/done strobes and pause/resume.
//            Define ROLL_SCHED_GEOMETRIC_EN for a doubling (instead of linear)
//            period growth.
// Revision : 1.0 - initial release
// ============================================================================
module roll_scheduler #(
   parameter int CNT_W       = 16,
   parameter int INIT_PERIOD = 4,
   parameter int PERIOD_STEP = 2,
   parameter int NUM_STEPS   = 3,
   parameter int STEP_W      = 8
) (
   input wire               i_clk,
   input wire               i_rst,
   roll_scheduler_if.slave  bus
);

   localparam logic [CNT_W-1:0]  c_PERIOD_MAX  = '1;
   localparam logic [CNT_W-1:0]  c_INIT_PERIOD = CNT_W'(INIT_PERIOD);
   localparam logic [STEP_W-1:0] c_LAST_STEP   = STEP_W'(NUM_STEPS - 1);
   // Wide enough that neither period+PERIOD_STEP nor period*2 can wrap.
   localparam int                c_SUM_W       = CNT_W + 33;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_PAUSE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [CNT_W-1:0]    period_q, period_d;
   logic [STEP_W-1:0]   step_q, step_d;
   logic                capture_q, capture_d;

   logic                w_tick;
   logic [c_SUM_W-1:0]  w_period_sum;
   logic [CNT_W-1:0]    w_period_next;

`ifdef ROLL_SCHED_GEOMETRIC_EN
   assign w_period_sum = c_SUM_W'(period_q) << 1;
`else
   assign w_period_sum = c_SUM_W'(period_q) + c_SUM_W'(PERIOD_STEP);
`endif

   assign w_period_next = (w_period_sum > c_SUM_W'(c_PERIOD_MAX)) ? c_PERIOD_MAX
                                                                   : w_period_sum[CNT_W-1:0];

   assign w_tick = (state_q == S_RUN) && (cnt_q == (period_q - CNT_W'(1)));

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         period_q  <= c_INIT_PERIOD;
         step_q    <= '0;
         capture_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         period_q  <= period_d;
         step_q    <= step_d;
         capture_q <= capture_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      period_d  = period_q;
      step_d    = step_q;
      capture_d = 1'b0;

      // A start restarts the roll from any state and overrides a pause.
      if (bus.i_start) begin
         state_d   = S_RUN;
         cnt_d     = '0;
         period_d  = c_INIT_PERIOD;
         step_d    = '0;
         capture_d = 1'b1;
      end else begin
         case (state_q)
            S_RUN: begin
               if (w_tick) begin
                  cnt_d    = '0;
                  step_d   = step_q + STEP_W'(1);
                  period_d = w_period_next;
                  if (step_q == c_LAST_STEP) begin
                     state_d = S_DONE;
                  end else if (bus.i_pause) begin
                     state_d = S_PAUSE;
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
                  if (bus.i_pause) begin
                     state_d = S_PAUSE;
                  end
               end
            end
            S_PAUSE: begin
               if (bus.i_pause) begin
                  state_d = S_RUN;
               end
            end
            S_DONE: begin
               state_d = S_IDLE;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   assign bus.o_tick    = w_tick;
   assign bus.o_capture = capture_q;
   assign bus.o_busy    = (state_q == S_RUN) || (state_q == S_PAUSE);
   assign bus.o_paused  = (state_q == S_PAUSE);
   assign bus.o_done    = (state_q == S_DONE);
   assign bus.o_step    = step_q;

endmodule

`default_nettype wire

// File: tb/tb_roll_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_roll_scheduler
// Brief    : Self-checking bench: countdown reference model plus directed
//            timing scenarios (defaults, pause, restart, async reset,
//            saturation) and a randomized key-pulse phase.
// Revision : 1.0 - initial release
// ============================================================================
module tb_roll_scheduler;

   localparam int CNT_W       = 16;
   localparam int INIT_PERIOD = 4;
   localparam int PERIOD_STEP = 2;
   localparam int NUM_STEPS   = 3;
   localparam int STEP_W      = 8;
   localparam longint PMAX    = (64'd1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   roll_scheduler_if #(.STEP_W(STEP_W)) bus ();
   roll_scheduler_if #(.STEP_W(STEP_W)) sbus ();

   roll_scheduler #(
      .CNT_W(CNT_W), .INIT_PERIOD(INIT_PERIOD), .PERIOD_STEP(PERIOD_STEP),
      .NUM_STEPS(NUM_STEPS), .STEP_W(STEP_W)
   ) u_dut (
      .i_clk(clk), .i_rst(rst), .bus(bus)
   );

   roll_scheduler #(
      .CNT_W(3), .INIT_PERIOD(6), .PERIOD_STEP(4), .NUM_STEPS(3), .STEP_W(STEP_W)
   ) u_sat (
      .i_clk(clk), .i_rst(rst), .bus(sbus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
      end
   endtask

   // ---------------- reference model: countdown to the next tick ----------
   bit     m_active, m_paused, m_cap, m_done;
   longint m_wait, m_period, m_step;

   function automatic longint next_period(input longint p);
      longint n;
`ifdef ROLL_SCHED_GEOMETRIC_EN
      n = p * 2;
`else
      n = p + PERIOD_STEP;
`endif
      return (n > PMAX) ? PMAX : n;
   endfunction

   task automatic model_reset();
      m_active = 0; m_paused = 0; m_cap = 0; m_done = 0;
      m_wait = 0; m_period = INIT_PERIOD; m_step = 0;
   endtask

   task automatic model_step(input logic s, input logic p);
      bit t;
      t = m_active && !m_paused && (m_wait == 1);
      m_cap  = 0;
      m_done = 0;
      if (s) begin
         m_active = 1; m_paused = 0; m_cap = 1;
         m_period = INIT_PERIOD; m_wait = INIT_PERIOD; m_step = 0;
      end else if (m_active && !m_paused) begin
         if (t) begin
            m_step++;
            m_period = next_period(m_period);
            m_wait   = m_period;
            if (m_step == NUM_STEPS) begin
               m_active = 0;
               m_done   = 1;
            end else if (p) begin
               m_paused = 1;
            end
         end else begin
            m_wait--;
            if (p) m_paused = 1;
         end
      end else if (m_active && m_paused && p) begin
         m_paused = 0;
      end
   endtask

   // Per-cycle comparison against the model, mid-cycle away from the edge.
   always @(negedge clk) begin
      if (rst) model_reset();
      check("model tick",    bus.o_tick,    64'(m_active && !m_paused && m_wait == 1));
      check("model capture", bus.o_capture, 64'(m_cap));
      check("model busy",    bus.o_busy,    64'(m_active));
      check("model paused",  bus.o_paused,  64'(m_active && m_paused));
      check("model done",    bus.o_done,    64'(m_done));
      check("model step",    bus.o_step,    64'(m_step));
      if (!rst) model_step(bus.i_start, bus.i_pause);
   end

   // ---------------- directed scenario logging ----------------------------
   int         base;
   bit         tick_a[64], cap_a[64], done_a[64], busy_a[64], paused_a[64];
   bit         stick_a[64], sdone_a[64];
   logic [7:0] step_a[64];

   task automatic cycle(input bit s, input bit p);
      int rel;
      @(posedge clk);
      #2;
      bus.i_start  = s;
      bus.i_pause  = p;
      sbus.i_start = s;
      @(negedge clk);
      #1;
      rel = cyc - base;
      if (rel >= 0 && rel < 64) begin
         tick_a[rel]   = bus.o_tick;
         cap_a[rel]    = bus.o_capture;
         done_a[rel]   = bus.o_done;
         busy_a[rel]   = bus.o_busy;
         paused_a[rel] = bus.o_paused;
         step_a[rel]   = bus.o_step;
         stick_a[rel]  = sbus.o_tick;
         sdone_a[rel]  = sbus.o_done;
      end
   endtask

   // Start at relative cycle 0, optional restart at st2 and pauses at p1/p2.
   task automatic run_scn(input int n, input int st2, input int p1, input int p2);
      for (int i = 0; i < 64; i++) begin
         tick_a[i] = 0; cap_a[i] = 0; done_a[i] = 0; busy_a[i] = 0;
         paused_a[i] = 0; stick_a[i] = 0; sdone_a[i] = 0; step_a[i] = 8'hxx;
      end
      base = cyc + 1;
      for (int r = 0; r < n; r++) cycle(r == 0 || r == st2, r == p1 || r == p2);
      bus.i_start = 0; bus.i_pause = 0; sbus.i_start = 0;
   endtask

   task automatic check_events(input string name, input bit a[64], input int e[$]);
      int q[$];
      for (int i = 0; i < 64; i++) if (a[i]) q.push_back(i);
      check({name, " count"}, 64'(q.size()), 64'(e.size()));
      for (int i = 0; i < e.size(); i++)
         check($sformatf("%s #%0d cycle", name, i + 1), (i < q.size()) ? 64'(q[i]) : '1, 64'(e[i]));
   endtask

   task automatic check_defaults_roll(input string tag, input int et[$], input int ed);
      int nb;
      check_events({tag, " tick"}, tick_a, et);
      check_events({tag, " capture"}, cap_a, '{1});
      check_events({tag, " done"}, done_a, '{ed});
      for (int i = 0; i < et.size(); i++)
         check($sformatf("%s step after tick %0d", tag, i + 1), step_a[et[i] + 1], 64'(i + 1));
      nb = 0;
      for (int i = 0; i < 64; i++) nb += int'(busy_a[i]);
      check({tag, " busy cycles"}, 64'(nb), 64'(et[et.size() - 1]));
      check({tag, " busy first"}, busy_a[1], 1);
      check({tag, " idle after done"}, busy_a[ed + 1], 0);
      check({tag, " step held"}, step_a[ed + 3], 64'(NUM_STEPS));
   endtask

   // ---------------- main sequence ----------------------------------------
   initial begin
      int e1t[$], e2t[$], e3t[$];
      int e1d, e2d, e3d, np;
`ifdef ROLL_SCHED_GEOMETRIC_EN
      e1t = '{4, 12, 28};     e1d = 29;
      e2t = '{4, 17, 33};     e2d = 34;
      e3t = '{4, 11, 19, 35}; e3d = 36;
`else
      e1t = '{4, 10, 18};     e1d = 19;
      e2t = '{4, 15, 23};     e2d = 24;
      e3t = '{4, 11, 17, 25}; e3d = 26;
`endif
      bus.i_start = 0; bus.i_pause = 0;
      sbus.i_start = 0; sbus.i_pause = 0;

      repeat (3) @(posedge clk);
      #2 rst = 0;
      #1;
      check("reset tick",    bus.o_tick,    0);
      check("reset capture", bus.o_capture, 0);
      check("reset busy",    bus.o_busy,    0);
      check("reset done",    bus.o_done,    0);
      check("reset step",    bus.o_step,    0);

      // Defaults, plus the 3-bit saturating instance started alongside.
      run_scn(e1d + 6, -1, -1, -1);
      check_defaults_roll("defaults", e1t, e1d);
      check_events("saturation tick", stick_a, '{6, 13, 20});
      check_events("saturation done", sdone_a, '{21});

      // Pause at 6, resume at 11.
      run_scn(e2d + 6, -1, 6, 11);
      check_events("pause tick", tick_a, e2t);
      check_events("pause done", done_a, '{e2d});
      np = 0;
      for (int i = 7; i <= 11; i++) np += int'(paused_a[i]) + 10 * int'(tick_a[i]);
      check("pause cycles k+7..k+11", 64'(np), 5);
      check("not paused at k+6",  paused_a[6],  0);
      check("not paused at k+12", paused_a[12], 0);

      // Restart at 7.
      run_scn(e3d + 6, 7, -1, -1);
      check_events("restart capture", cap_a, '{1, 8});
      check_events("restart tick", tick_a, e3t);
      check_events("restart done", done_a, '{e3d});
      check("restart step before", step_a[7], 1);
      check("restart step cleared", step_a[8], 0);

      // Asynchronous reset between edges in the middle of a roll.
      run_scn(8, -1, -1, -1);
      check("pre-reset busy", bus.o_busy, 1);
      @(posedge clk);
      #3 rst = 1;
      #1;
      check("async reset tick",    bus.o_tick,    0);
      check("async reset capture", bus.o_capture, 0);
      check("async reset busy",    bus.o_busy,    0);
      check("async reset paused",  bus.o_paused,  0);
      check("async reset done",    bus.o_done,    0);
      check("async reset step",    bus.o_step,    0);
      @(posedge clk);
      #2 rst = 0;
      run_scn(e1d + 6, -1, -1, -1);
      check_defaults_roll("after reset", e1t, e1d);

      // Randomized key pulses with occasional mid-cycle resets.
      for (int i = 0; i < 2000; i++) begin
         @(posedge clk);
         #2;
         if (rst) rst = 0;
         bus.i_start = ($urandom_range(0, 99) < 3);
         bus.i_pause = ($urandom_range(0, 99) < 10);
         if ($urandom_range(0, 499) == 0) begin
            #1 rst = 1;
         end
      end
      @(posedge clk);
      #2;
      rst = 0;
      bus.i_start = 0;
      bus.i_pause = 0;
      repeat (20) @(posedge clk);
      #3;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached at %0t", $time);
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire

// File: doc/roll_scheduler.md
Name: roll_scheduler

Overview:
Sequencer for the lab random-number datapath. A start pulse launches a decelerating "roll": it emits NUM_STEPS single-cycle advance ticks to the generator, and the gap between ticks grows after each tick. It also raises a capture strobe so the previous result can be latched, and supports pause/resume from a key. It sits between the debounced key pulses and the generator/result registers.

Parameters:
CNT_W, 16, width of the interval counter and the period register
INIT_PERIOD, 4, clock cycles before the first tick (must be at least 1, at most 2^CNT_W-1)
PERIOD_STEP, 2, cycles added to the period after each tick
NUM_STEPS, 3, ticks per roll (must be at least 1)
STEP_W, 8, width of o_step (must hold NUM_STEPS)

Ports:
i_clk  input  1  system clock
i_rst  input  1  reset; asynchronous, active-high
i_start  input  1  single-cycle start pulse (debounced key)
i_pause  input  1  single-cycle pause/resume toggle pulse
o_tick  output  1  single-cycle advance strobe to the generator
o_capture  output  1  single-cycle strobe to latch the previous result
o_busy  output  1  high while in RUN or PAUSE
o_paused  output  1  high while in PAUSE
o_done  output  1  single-cycle strobe at the end of a roll
o_step  output  STEP_W  ticks issued in the current roll

Behaviour:
- States: IDLE, RUN, PAUSE, DONE.
- Registers: state, cnt[CNT_W], period[CNT_W], step[STEP_W].
- All outputs are decoded from registers only (no combinational input-to-output paths).
- Reset (any time, including mid-roll):
  - state=IDLE, cnt=0, period=INIT_PERIOD, step=0.
  - All outputs are 0.
- IDLE or DONE, i_start=1 → next state RUN.
  - Load cnt=0, period=INIT_PERIOD, step=0.
  - o_capture=1 in the first RUN cycle only.
- RUN:
  - cnt increments each cycle.
  - o_tick=1 in the cycle where cnt==period-1.
  - On that edge: cnt←0, step←step+1, and period←min(period+PERIOD_STEP, 2^CNT_W-1) (saturating).
  - When the tick being issued is tick number NUM_STEPS, the next state is DONE.
- DONE: o_done=1 for exactly one cycle, then IDLE. o_step keeps its final value until the next start.
- RUN, i_pause=1 → PAUSE.
  - cnt, period and step are frozen.
  - The pause takes effect at the edge, so a tick already due in that cycle is still issued.
  - If that tick is the last one, DONE takes priority and the pause is dropped.
- PAUSE, i_pause=1 → RUN, continuing from the frozen cnt. No ticks are issued during PAUSE.
- i_start while in RUN or PAUSE restarts the roll: same loads as a start from IDLE, and o_capture is asserted again.
- Simultaneous i_start and i_pause: i_start wins and i_pause is ignored.
- i_pause in IDLE or DONE: ignored.
- Latency: a start sampled at the edge ending cycle k gives:
  - o_capture in cycle k+1;
  - first tick in cycle k+INIT_PERIOD;
  - tick n in cycle k + sum of the periods for ticks 1..n.
- Timing with defaults and start at cycle k:
  - ticks at k+4, k+10, k+18;
  - o_done at k+19;
  - o_busy high for k+1..k+18.

Optional Feature:
ROLL_SCHED_GEOMETRIC_EN
- Defined: after each tick, period←min(period×2, 2^CNT_W-1) (left shift with saturation). PERIOD_STEP is ignored.
- Undefined: linear increment as described in Behaviour.
- All other behaviour is identical in both builds.

Test Plan:
- Defaults, start pulse at cycle k:
  - o_capture at k+1;
  - o_tick at k+4, k+10, k+18;
  - o_step goes 1, 2, 3;
  - o_done at k+19, then IDLE with o_busy=0.
- Pause at k+6, resume 5 cycles later at k+11:
  - no ticks in k+7..k+11;
  - o_paused=1 during k+7..k+11;
  - second tick slips by 5 to k+15, third tick to k+23.
- Restart at k+7: o_capture at k+8, o_step=0 at k+8, ticks at k+11, k+17, k+25.
- i_rst asserted asynchronously mid-RUN between edges:
  - all outputs 0 immediately, state IDLE;
  - a later start behaves exactly as the defaults scenario.
- Saturation with CNT_W=3, INIT_PERIOD=6, PERIOD_STEP=4, NUM_STEPS=3: periods 6, 7, 7 → ticks at k+6, k+13, k+20.
- Build with ROLL_SCHED_GEOMETRIC_EN defined, defaults: ticks at k+4, k+12, k+28; o_done at k+29.
